// File: rtl/fsm_controller_multi.sv
// fsm_controller_multi
//   Multi-channel controller for the ring-oscillator temperature sensor.
//   It decodes UART command bytes, selects a measurement channel, and enables the
//   measurement. It then serialises the result frame to the UART transmitter. The
//   bytes are paced by the transmitter's tx_busy handshake plus a gap timer.
//
//   Command byte: [7:6] opcode (00 continuous, 01 single-shot, 11 stop,
//   10 invalid); [CH_W-1:0] channel; the bits in between are ignored.
//
//   Optional build macro FRAME_HEADER_EN: each frame starts with a header byte
//   selected by send_sel = NUM_BYTES, followed by data bytes 0..NUM_BYTES-1.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   rx_ready   one-cycle pulse, rx_data valid
//   rx_data    received command byte
//   sum_ready  measurement result valid (level or pulse)
//   tx_busy    UART transmitter busy
//   sum_en     measurement enable (WAIT_SUM only)
//   ch_sel     active channel index, stable for a whole frame
//   tx_send    one-cycle byte-send strobe
//   send_sel   result byte selector for the datapath mux
//   busy       high whenever the controller is not idle
//   cmd_err    one-cycle pulse when an invalid command is decoded
//
// Handshake: a byte is launched by a one-cycle tx_send. The transmitter
// acknowledges by raising tx_busy, and it finishes by dropping tx_busy. If
// tx_busy never rises within ACK_TIMEOUT cycles, the byte is dropped and the
// frame continues.
module fsm_controller_multi #(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 2,
    parameter int NUM_BYTES   = 3,
    parameter int SEL_W       = 3,
    parameter int GAP_CYCLES  = 100,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_ready,
    input  logic [7:0]       rx_data,
    input  logic             sum_ready,
    input  logic             tx_busy,
    output logic             sum_en,
    output logic [CH_W-1:0]  ch_sel,
    output logic             tx_send,
    output logic [SEL_W-1:0] send_sel,
    output logic             busy,
    output logic             cmd_err
);

    typedef enum logic [2:0] {
        IDLE, DECODE, WAIT_SUM, SEND, WAIT_ACK, WAIT_DONE, GAP
    } state_t;

    localparam logic [15:0]      GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [15:0]      ACK_LAST = 16'(ACK_TIMEOUT - 1);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_BYTES - 1);
`ifdef FRAME_HEADER_EN
    localparam logic [SEL_W-1:0] FIRST_IDX = SEL_W'(NUM_BYTES);
`else
    localparam logic [SEL_W-1:0] FIRST_IDX = '0;
`endif

    state_t           state, state_next;
    logic [7:0]       cmd_q, cmd_next;
    logic             pend_valid, pend_valid_next;
    logic [7:0]       pend_q, pend_next;
    logic [CH_W-1:0]  ch_q, ch_next;
    logic             single_q, single_next;
    logic [SEL_W-1:0] idx_q, idx_next;
    logic [15:0]      timer_q;

    // Command decode of the captured byte.
    logic [1:0]      opcode;
    logic [CH_W-1:0] cmd_ch;
    logic            ch_ok, cmd_start, cmd_stop;
    logic [7:0]      unused_cmd_bits;

    assign opcode    = cmd_q[7:6];
    assign cmd_ch    = cmd_q[CH_W-1:0];
    assign ch_ok     = {1'b0, cmd_ch} < (CH_W + 1)'(NUM_CH);
    assign cmd_start = (opcode == 2'b00 || opcode == 2'b01) && ch_ok;
    assign cmd_stop  = (opcode == 2'b11);
    // The middle command bits are don't-care.
    assign unused_cmd_bits = cmd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cmd_q      <= '0;
            pend_valid <= 1'b0;
            pend_q     <= '0;
            ch_q       <= '0;
            single_q   <= 1'b0;
            idx_q      <= '0;
            timer_q    <= '0;
        end else begin
            state      <= state_next;
            cmd_q      <= cmd_next;
            pend_valid <= pend_valid_next;
            pend_q     <= pend_next;
            ch_q       <= ch_next;
            single_q   <= single_next;
            idx_q      <= idx_next;
            // Timer restarts on every state change and saturates.
            if (state_next != state)
                timer_q <= '0;
            else if (timer_q != 16'hFFFF)
                timer_q <= timer_q + 16'd1;
        end
    end

    always_comb begin
        state_next      = state;
        cmd_next        = cmd_q;
        pend_valid_next = pend_valid;
        pend_next       = pend_q;
        ch_next         = ch_q;
        single_next     = single_q;
        idx_next        = idx_q;
        sum_en          = 1'b0;
        tx_send         = 1'b0;
        send_sel        = '0;
        cmd_err         = 1'b0;

        // While a frame is in flight, commands wait in a one-deep register.
        // A newer byte replaces an older one.
        if (rx_ready && (state == SEND || state == WAIT_ACK ||
                         state == WAIT_DONE || state == GAP)) begin
            pend_valid_next = 1'b1;
            pend_next       = rx_data;
        end

        case (state)
            IDLE: begin
                if (rx_ready) begin
                    cmd_next   = rx_data;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (cmd_start) begin
                    ch_next     = cmd_ch;
                    single_next = opcode[0];
                    idx_next    = FIRST_IDX;
                    state_next  = WAIT_SUM;
                end else begin
                    cmd_err    = !cmd_stop;
                    state_next = IDLE;
                end
            end
            WAIT_SUM: begin
                sum_en = 1'b1;
                // A new command wins over a simultaneous result.
                if (rx_ready) begin
                    cmd_next   = rx_data;
                    state_next = DECODE;
                end else if (sum_ready) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                tx_send    = 1'b1;
                send_sel   = idx_q;
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                send_sel = idx_q;
                if (tx_busy)
                    state_next = WAIT_DONE;
                else if (timer_q == ACK_LAST)
                    state_next = GAP;
            end
            WAIT_DONE: begin
                send_sel = idx_q;
                if (!tx_busy)
                    state_next = GAP;
            end
            GAP: begin
                send_sel = idx_q;
                if (timer_q == GAP_LAST) begin
`ifdef FRAME_HEADER_EN
                    if (idx_q == FIRST_IDX) begin
                        idx_next   = '0;
                        state_next = SEND;
                    end else
`endif
                    if (idx_q < LAST_IDX) begin
                        idx_next   = idx_q + 1'b1;
                        state_next = SEND;
                    end else if (pend_valid || rx_ready) begin
                        // A byte arriving this very cycle is the newest command.
                        cmd_next        = rx_ready ? rx_data : pend_q;
                        pend_valid_next = 1'b0;
                        state_next      = DECODE;
                    end else if (!single_q) begin
                        idx_next   = FIRST_IDX;
                        state_next = WAIT_SUM;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ch_sel = ch_q;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_fsm_controller_multi.sv
// tb_fsm_controller_multi
//   Directed and randomized bench for fsm_controller_multi. The bench acts as
//   the UART host and the transmitter. It predicts each tx_send time and
//   send_sel value from the frame rules:
//     first byte one cycle after sum_ready,
//     next byte GAP_CYCLES+1 cycles after tx_busy falls,
//     or ACK_TIMEOUT+GAP_CYCLES+1 cycles after an unacknowledged strobe.
//   It also predicts the end-of-frame outcome (pending command, continuous or
//   single-shot mode).
module tb_fsm_controller_multi;

    localparam int NUM_CH      = 6;
    localparam int CH_W        = 3;
    localparam int NUM_BYTES   = 3;
    localparam int SEL_W       = 3;
    localparam int GAP_CYCLES  = 12;
    localparam int ACK_TIMEOUT = 40;
`ifdef FRAME_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic             clk = 1'b0;
    logic             reset, rx_ready, sum_ready, tx_busy;
    logic [7:0]       rx_data;
    logic             sum_en, tx_send, busy, cmd_err;
    logic [CH_W-1:0]  ch_sel;
    logic [SEL_W-1:0] send_sel;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int send_cnt = 0;

    // Reference model state.
    logic [CH_W-1:0] m_ch;
    bit              m_single;
    bit              m_wait;      // controller expected in WAIT_SUM
    logic [8:0]      inj_at [0:7]; // command injected at frame byte b (bit 8 = present)

    fsm_controller_multi #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .NUM_BYTES(NUM_BYTES), .SEL_W(SEL_W),
        .GAP_CYCLES(GAP_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
        .sum_ready(sum_ready), .tx_busy(tx_busy), .sum_en(sum_en),
        .ch_sel(ch_sel), .tx_send(tx_send), .send_sel(send_sel),
        .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample one time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tx_send === 1'b1) send_cnt++;
    endtask

    // 0 = start, 1 = stop, 2 = invalid
    function automatic int cmd_kind(input logic [7:0] b);
        int op, ch;
        op = int'(b) / 64;
        ch = int'(b) % (1 << CH_W);
        if (op == 2) return 2;
        if (op == 3) return 1;
        if (ch >= NUM_CH) return 2;
        return 0;
    endfunction

    // The state one cycle after DECODE of byte b.
    task automatic apply_result(input logic [7:0] b, input string tag);
        if (cmd_kind(b) == 0) begin
            m_ch     = CH_W'(int'(b) % (1 << CH_W));
            m_single = (int'(b) / 64) == 1;
            m_wait   = 1'b1;
            check({tag, " busy after start"}, busy, 1);
            check({tag, " sum_en after start"}, sum_en, 1);
        end else begin
            m_wait = 1'b0;
            check({tag, " busy after stop/err"}, busy, 0);
            check({tag, " sum_en after stop/err"}, sum_en, 0);
        end
        check({tag, " ch_sel"}, ch_sel, m_ch);
        check({tag, " cmd_err clear"}, cmd_err, 0);
    endtask

    // Issue a command from IDLE or WAIT_SUM.
    task automatic send_cmd(input logic [7:0] b, input string tag);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
        rx_data  = 8'($urandom);
        check({tag, " decode busy"}, busy, 1);
        check({tag, " decode cmd_err"}, cmd_err, cmd_kind(b) == 2);
        check({tag, " decode sum_en"}, sum_en, 0);
        tick();
        apply_result(b, tag);
    endtask

    // Pulse sum_ready and serve the whole frame as the transmitter.
    task automatic serve_frame(input string tag, input bit rand_ack, input int to_mask);
        int nb, exp_t, base, d, l;
        bit to;
        logic [SEL_W-1:0] esel;
        nb   = NUM_BYTES + HDR;
        base = send_cnt;
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        exp_t = cyc;
        for (int b = 0; b < nb; b++) begin
            while (cyc < exp_t) tick();
            esel = (b < HDR) ? SEL_W'(NUM_BYTES) : SEL_W'(b - HDR);
            check({tag, " tx_send on time"}, tx_send, 1);
            check({tag, " one strobe per byte"}, send_cnt - base, 1);
            base = send_cnt;
            check({tag, " send_sel"}, send_sel, esel);
            check({tag, " ch_sel in frame"}, ch_sel, m_ch);
            check({tag, " sum_en in frame"}, sum_en, 0);
            if (rand_ack) begin
                to = ($urandom_range(0, 5) == 0);
                d  = $urandom_range(1, 3);
                l  = $urandom_range(1, 6);
            end else begin
                to = to_mask[b];
                d  = 1;
                l  = 10;
            end
            if (inj_at[b][8]) begin
                rx_ready = 1'b1;
                rx_data  = inj_at[b][7:0];
            end
            tick();
            rx_ready = 1'b0;
            check({tag, " send_sel held"}, send_sel, esel);
            if (to) begin
                exp_t = cyc - 1 + ACK_TIMEOUT + GAP_CYCLES + 1;
            end else begin
                repeat (d - 1) tick();
                tx_busy = 1'b1;
                repeat (l) tick();
                tx_busy = 1'b0;
                exp_t = cyc + GAP_CYCLES + 1;
            end
        end
        while (cyc < exp_t) tick();
        check({tag, " no extra strobe"}, send_cnt - base, 0);
    endtask

    // Check the end-of-frame outcome against the model.
    task automatic finish_frame(input string tag);
        bit have;
        logic [7:0] p;
        have = 1'b0;
        p = '0;
        for (int b = 0; b < 8; b++) begin
            if (inj_at[b][8]) begin
                have = 1'b1;
                p    = inj_at[b][7:0];
            end
            inj_at[b] = '0;
        end
        if (have) begin
            check({tag, " pending decode busy"}, busy, 1);
            check({tag, " pending decode cmd_err"}, cmd_err, cmd_kind(p) == 2);
            check({tag, " pending decode sum_en"}, sum_en, 0);
            tick();
            apply_result(p, tag);
        end else if (!m_single) begin
            check({tag, " continuous sum_en"}, sum_en, 1);
            check({tag, " continuous busy"}, busy, 1);
        end else begin
            m_wait = 1'b0;
            check({tag, " single busy"}, busy, 0);
            check({tag, " single sum_en"}, sum_en, 0);
        end
    endtask

    initial begin
        int base;
        logic [7:0] b;
        reset = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; sum_ready = 1'b0; tx_busy = 1'b0;
        m_ch = '0; m_single = 1'b0; m_wait = 1'b0;
        for (int i = 0; i < 8; i++) inj_at[i] = '0;
        repeat (3) tick();
        check("reset busy", busy, 0);
        check("reset sum_en", sum_en, 0);
        check("reset tx_send", tx_send, 0);
        check("reset ch_sel", ch_sel, 0);
        check("reset send_sel", send_sel, 0);
        check("reset cmd_err", cmd_err, 0);
        reset = 1'b0;
        tick();

        // Continuous on channel 0, ack after every strobe.
        send_cmd(8'h00, "cont0");
        repeat (20) tick();
        check("cont0 waiting sum_en", sum_en, 1);
        serve_frame("cont0", 1'b0, 0);
        finish_frame("cont0");

        // Single-shot on channel 3.
        send_cmd(8'h43, "single3");
        serve_frame("single3", 1'b0, 0);
        finish_frame("single3");

        // Invalid opcode, then out-of-range channels; channel is retained.
        send_cmd(8'h85, "bad_op");
        send_cmd(8'h07, "bad_ch7");
        send_cmd(8'h06, "bad_ch6");

        // Top valid channel, single-shot, first data byte never acknowledged.
        send_cmd(8'h45, "timeout");
        serve_frame("timeout", 1'b0, 1 << HDR);
        finish_frame("timeout");

        // Stop received during data byte 1: frame completes, then idle.
        send_cmd(8'h01, "stop_mid");
        inj_at[HDR + 1] = {1'b1, 8'hC0};
        serve_frame("stop_mid", 1'b0, 0);
        finish_frame("stop_mid");

        // rx_ready and sum_ready together in WAIT_SUM: command wins.
        send_cmd(8'h02, "prio_pre");
        rx_ready = 1'b1; rx_data = 8'h04; sum_ready = 1'b1;
        base = send_cnt;
        tick();
        rx_ready = 1'b0; sum_ready = 1'b0;
        check("prio decode tx_send", tx_send, 0);
        check("prio decode sum_en", sum_en, 0);
        tick();
        apply_result(8'h04, "prio");
        repeat (5) tick();
        check("prio no strobe", send_cnt - base, 0);

        // Newer pending command overwrites an older invalid one.
        inj_at[0] = {1'b1, 8'h85};
        inj_at[2] = {1'b1, 8'h7C};
        serve_frame("overwrite", 1'b0, 0);
        finish_frame("overwrite");
        serve_frame("overwrite2", 1'b1, 0);
        finish_frame("overwrite2");

        // Reset while the transmitter is busy, with a command pending.
        send_cmd(8'h02, "rst_pre");
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        check("rst first strobe", tx_send, 1);
        rx_ready = 1'b1; rx_data = 8'h01;
        tick();
        rx_ready = 1'b0;
        tx_busy = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check("rst busy", busy, 0);
        check("rst tx_send", tx_send, 0);
        check("rst sum_en", sum_en, 0);
        check("rst ch_sel", ch_sel, 0);
        check("rst send_sel", send_sel, 0);
        check("rst cmd_err", cmd_err, 0);
        reset = 1'b0;
        tx_busy = 1'b0;
        m_ch = '0; m_wait = 1'b0;
        base = send_cnt;
        repeat (60) tick();
        check("rst stays idle", busy, 0);
        check("rst no strobe", send_cnt - base, 0);

        // Randomized frames with random pacing and mid-frame commands.
        for (int it = 0; it < 10; it++) begin
            if (!m_wait || $urandom_range(0, 1) == 1) begin
                b = 8'($urandom_range(0, 1) * 64 + $urandom_range(0, 7) * 8 +
                       $urandom_range(0, NUM_CH - 1));
                send_cmd(b, "rnd_cmd");
            end
            for (int k = 0; k < NUM_BYTES + HDR; k++)
                if ($urandom_range(0, 3) == 0)
                    inj_at[k] = {1'b1, 8'($urandom_range(0, 255))};
            serve_frame("rnd", 1'b1, 0);
            finish_frame("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
